// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - internally timed LED blink/burst engine with registered, polarity-selectable outputs.
// Optional macro LED_PWM_DIM_EN adds the i_brightness port and a global 16-step PWM dimmer.
module led_pattern_engine #(
    parameter int NUM_LED    = 16,
    parameter int TICK_DIV   = 3125000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                   i_sysclk,
    input  logic                   i_reset,
    input  logic [4*NUM_LED-1:0]   i_led_mode,
    input  logic [NUM_LED-1:0]     i_led_trig,
    input  logic [3:0]             i_burst_cnt,
    input  logic                   i_phase_clr,
    output logic [NUM_LED-1:0]     o_led_out,
    output logic [NUM_LED-1:0]     o_led_busy
`ifdef LED_PWM_DIM_EN
    ,
    input  logic [3:0]             i_brightness
`endif
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_TC  = PW'(TICK_DIV - 1);
    localparam logic [3:0]    MODE_OFF  = 4'd0;
    localparam logic [3:0]    MODE_1HZ  = 4'd1;
    localparam logic [3:0]    MODE_2HZ  = 4'd2;
    localparam logic [3:0]    MODE_4HZ  = 4'd3;
    localparam logic [3:0]    MODE_05S  = 4'd4;
    localparam logic [3:0]    MODE_35S  = 4'd5;
    localparam logic [3:0]    MODE_ON   = 4'd6;
    localparam logic [3:0]    MODE_BRST = 4'd7;

    logic [PW-1:0]      r_presc;
    logic [4:0]         r_ph;
    logic [4:0]         r_rem [NUM_LED];
    logic [NUM_LED-1:0] r_led_out;
    logic [NUM_LED-1:0] r_busy;

    logic               w_tick;
    logic [NUM_LED-1:0] w_lit;
    logic [NUM_LED-1:0] w_drive;
    logic [4:0]         w_rem_nxt [NUM_LED];

    assign w_tick = (r_presc == PRESC_TC);

    // Phase clear realigns every channel at once; burst counters are left alone.
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            r_presc <= '0;
            r_ph    <= 5'd0;
        end else if (i_phase_clr) begin
            r_presc <= '0;
            r_ph    <= 5'd0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_ph    <= r_ph + 5'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    for (genvar g = 0; g < NUM_LED; g++) begin : g_chan
        logic [3:0] w_mode;
        assign w_mode = i_led_mode[4*g +: 4];

        // A load takes priority over a coincident tick so a burst always starts at 2*count.
        always_comb begin
            w_rem_nxt[g] = r_rem[g];
            if (w_mode != MODE_BRST)
                w_rem_nxt[g] = 5'd0;
            else if (i_led_trig[g] && (r_rem[g] == 5'd0) && (i_burst_cnt != 4'd0))
                w_rem_nxt[g] = {i_burst_cnt, 1'b0};
            else if (w_tick && (r_rem[g] != 5'd0))
                w_rem_nxt[g] = r_rem[g] - 5'd1;
        end

        always_comb begin
            w_lit[g] = 1'b0;
            case (w_mode)
                MODE_OFF:  w_lit[g] = 1'b0;
                MODE_1HZ:  w_lit[g] = ~r_ph[2];
                MODE_2HZ:  w_lit[g] = ~r_ph[1];
                MODE_4HZ:  w_lit[g] = ~r_ph[0];
                MODE_05S:  w_lit[g] = (r_ph < 5'd4);
                MODE_35S:  w_lit[g] = (r_ph < 5'd28);
                MODE_ON:   w_lit[g] = 1'b1;
                MODE_BRST: w_lit[g] = (r_rem[g] != 5'd0) & ~r_rem[g][0];
                default:   w_lit[g] = 1'b0;
            endcase
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [3:0] r_pwm;

    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset)
            r_pwm <= 4'd0;
        else
            r_pwm <= r_pwm + 4'd1;
    end

    assign w_drive = w_lit & {NUM_LED{(r_pwm <= i_brightness)}};
`else
    assign w_drive = w_lit;
`endif

    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_LED; i++)
                r_rem[i] <= 5'd0;
            r_busy    <= '0;
            r_led_out <= {NUM_LED{ACTIVE_LOW != 0}};
        end else begin
            for (int i = 0; i < NUM_LED; i++) begin
                r_rem[i]  <= w_rem_nxt[i];
                r_busy[i] <= (w_rem_nxt[i] != 5'd0);
            end
            r_led_out <= w_drive ^ {NUM_LED{ACTIVE_LOW != 0}};
        end
    end

    assign o_led_out  = r_led_out;
    assign o_led_busy = r_busy;

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - directed self-checking bench for led_pattern_engine (TICK_DIV=4, NUM_LED=4).
module tb_led_pattern_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mode;
    logic [3:0]  trig;
    logic [3:0]  burst;
    logic        clr;
    logic [3:0]  led_out;
    logic [3:0]  led_busy;
    logic [3:0]  led_out_al;
    logic [3:0]  led_busy_al;
`ifdef LED_PWM_DIM_EN
    logic [3:0]  bright;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    led_pattern_engine #(.NUM_LED(4), .TICK_DIV(4), .ACTIVE_LOW(0)) u_dut (
        .i_sysclk    (clk),
        .i_reset     (rst),
        .i_led_mode  (mode),
        .i_led_trig  (trig),
        .i_burst_cnt (burst),
        .i_phase_clr (clr),
        .o_led_out   (led_out),
        .o_led_busy  (led_busy)
`ifdef LED_PWM_DIM_EN
        ,
        .i_brightness(bright)
`endif
    );

    led_pattern_engine #(.NUM_LED(4), .TICK_DIV(4), .ACTIVE_LOW(1)) u_dut_al (
        .i_sysclk    (clk),
        .i_reset     (rst),
        .i_led_mode  (mode),
        .i_led_trig  (trig),
        .i_burst_cnt (burst),
        .i_phase_clr (clr),
        .o_led_out   (led_out_al),
        .o_led_busy  (led_busy_al)
`ifdef LED_PWM_DIM_EN
        ,
        .i_brightness(bright)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // cyc counts rising edges since the last phase reference point.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic goto(input int k);
        if (k > cyc) step(k - cyc);
    endtask

    logic [31:0] pat;
    logic [31:0] bz;
    int          hi;

    initial begin
        rst = 1'b1; mode = 16'h0000; trig = 4'h0; burst = 4'd0; clr = 1'b0;
`ifdef LED_PWM_DIM_EN
        bright = 4'd15;
`endif
        step(2);
        chk("reset_led_out", {28'd0, led_out}, 32'h0);
        chk("reset_busy", {28'd0, led_busy}, 32'h0);
        chk("reset_led_out_active_low", {28'd0, led_out_al}, 32'hF);

        rst = 1'b0; cyc = 0;
        step(3);
        chk("idle_led_out", {28'd0, led_out}, 32'h0);
        chk("idle_busy", {28'd0, led_busy}, 32'h0);

        // LED0..3 = 1Hz, 2Hz, 4Hz, ON
        mode = 16'h6321;
        goto(4);   chk("blink_k4",   {28'd0, led_out}, 32'hF);
        goto(5);   chk("blink_k5",   {28'd0, led_out}, 32'hB);
                   chk("blink_k5_al", {28'd0, led_out_al}, 32'h4);
        goto(9);   chk("blink_k9",   {28'd0, led_out}, 32'hD);
        goto(13);  chk("blink_k13",  {28'd0, led_out}, 32'h9);
        goto(17);  chk("blink_k17",  {28'd0, led_out}, 32'hE);
        goto(29);  chk("blink_k29",  {28'd0, led_out}, 32'h8);
        goto(33);  chk("blink_k33",  {28'd0, led_out}, 32'hF);
        goto(128); chk("ph31_k128",  {28'd0, led_out}, 32'h8);
        goto(129); chk("ph_wrap_k129", {28'd0, led_out}, 32'hF);

        // LED0 = 500ms, LED1 = 3.5s, LED2 = OFF, LED3 = reserved
        mode = 16'h8054;
        goto(130); chk("long_k130", {28'd0, led_out}, 32'h3);
        goto(144); chk("long_k144", {28'd0, led_out}, 32'h3);
        goto(145); chk("long_k145", {28'd0, led_out}, 32'h2);
        goto(240); chk("long_k240", {28'd0, led_out}, 32'h2);
        goto(241); chk("long_k241", {28'd0, led_out}, 32'h0);

        // PH is 17 here; phase clear restarts the frame
        goto(325);
        clr = 1'b1;
        step(1);
        clr = 1'b0; cyc = 0;
        chk("clr_k0",  {28'd0, led_out}, 32'h2);
        goto(1);   chk("clr_k1",  {28'd0, led_out}, 32'h3);
        goto(16);  chk("clr_k16", {28'd0, led_out}, 32'h3);
        goto(17);  chk("clr_k17", {28'd0, led_out}, 32'h2);

        // Burst of 3 on LED2 with a retrigger attempt mid-burst
        mode = 16'h0700; burst = 4'd3; trig = 4'b0100;
        step(1);
        trig = 4'h0;
        pat = '0; bz = '0;
        for (int i = 0; i < 32; i++) begin
            pat[i] = led_out[2];
            bz[i]  = led_busy[2];
            if (cyc == 21) begin
                trig = 4'b0100; burst = 4'd5;
            end else begin
                trig = 4'h0; burst = 4'd3;
            end
            step(1);
        end
        chk("burst_pattern", pat, 32'h0007_8786);
        chk("burst_busy", bz, 32'h003F_FFFF);
        hi = 0;
        for (int i = 1; i < 32; i++)
            if (pat[i] && !pat[i-1]) hi++;
        chk("burst_pulse_count", hi, 32'd3);

        // Trigger on a tick cycle loads 6, not 5
        goto(51);
        trig = 4'b0100; burst = 4'd3;
        step(1);
        trig = 4'h0;
        chk("tick_trig_busy", {28'd0, led_busy}, 32'h4);
        goto(53);  chk("tick_trig_lit", {28'd0, led_out}, 32'h4);
        goto(56);  chk("tick_trig_k56", {28'd0, led_out}, 32'h4);
        goto(57);  chk("tick_trig_k57", {28'd0, led_out}, 32'h0);
        mode = 16'h0000;
        step(1);
        chk("mode_leave_busy", {28'd0, led_busy}, 32'h0);
        chk("mode_leave_led", {28'd0, led_out}, 32'h0);

        mode = 16'h0700; burst = 4'd0; trig = 4'b0100;
        step(1);
        chk("burst_cnt0_busy", {28'd0, led_busy}, 32'h0);
        mode = 16'h0600; burst = 4'd3; trig = 4'b0100;
        step(1);
        chk("non7_trig_busy", {28'd0, led_busy}, 32'h0);
        chk("non7_on_led", {28'd0, led_out}, 32'h4);

        // Reset mid-burst
        mode = 16'h0700; burst = 4'd3; trig = 4'b0100;
        step(1);
        trig = 4'h0;
        step(1);
        chk("preabort_busy", {28'd0, led_busy}, 32'h4);
        chk("preabort_led", {28'd0, led_out}, 32'h4);
        rst = 1'b1;
        #1;
        chk("abort_led", {28'd0, led_out}, 32'h0);
        chk("abort_busy", {28'd0, led_busy}, 32'h0);
        chk("abort_led_al", {28'd0, led_out_al}, 32'hF);
        step(2);
        rst = 1'b0;
        step(10);
        chk("no_resume_busy", {28'd0, led_busy}, 32'h0);
        chk("no_resume_led", {28'd0, led_out}, 32'h0);

`ifdef LED_PWM_DIM_EN
        mode = 16'h0006; bright = 4'd3;
        step(4);
        hi = 0;
        for (int i = 0; i < 32; i++) begin
            if (led_out[0]) hi++;
            step(1);
        end
        chk("pwm_duty_b3", hi, 32'd8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
